// File: rtl/maxnet_pkg.sv
// Shared constants and types for the Maxnet sequencing controller.
package maxnet_pkg;

   localparam int N_DEF      = 4;
   localparam int ITER_W_DEF = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W_DEF = idx_width(N_DEF);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_CALC   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_CHECK  = 3'd4,
      ST_DONE   = 3'd5
   } maxnet_state_e;

endpackage

// File: rtl/maxnet_winner_detect.sv
// Combinational survivor detection: popcount <= 1 and lowest set index of nz flags.
module maxnet_winner_detect
   import maxnet_pkg::*;
#(
   parameter  int N     = N_DEF,
   localparam int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     i_nz_flags,
   output logic             o_le_one,
   output logic [IDX_W-1:0] o_lowest_idx
);

   // Clearing the lowest set bit leaves zero only when at most one bit was set.
   assign o_le_one = ((i_nz_flags & (i_nz_flags - N'(1))) == '0);

   always_comb begin
      o_lowest_idx = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (i_nz_flags[j]) o_lowest_idx = IDX_W'(j);
      end
   end

endmodule

// File: rtl/maxnet_controller.sv
// Maxnet sequencing FSM: load N activations, iterate compute/update/check until one survives.
// Optional iteration limit enabled by defining MAXNET_ITER_LIMIT_EN.
//
// state  | meaning
// IDLE   | waiting for a start rising edge
// LOAD   | streaming N activations from input memory
// CALC   | datapath computes next activations
// UPDATE | next activations latched, iteration counted
// CHECK  | survivors evaluated, decide to stop or iterate
// DONE   | results held until next start rising edge
module maxnet_controller
   import maxnet_pkg::*;
#(
   parameter  int N        = N_DEF,
   parameter  int ITER_W   = ITER_W_DEF,
   parameter  int MAX_ITER = 255,
   localparam int IDX_W    = idx_width(N)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [N-1:0]      i_nz_flags,
   output logic [IDX_W-1:0]  o_mem_addr,
   output logic              o_ld_init,
   output logic              o_calc_en,
   output logic              o_ld_update,
   output logic [ITER_W-1:0] o_iter_count,
   output logic [IDX_W-1:0]  o_winner,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_timeout
);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_LOAD   = ST_LOAD;
   localparam logic [2:0] S_CALC   = ST_CALC;
   localparam logic [2:0] S_UPDATE = ST_UPDATE;
   localparam logic [2:0] S_CHECK  = ST_CHECK;
   localparam logic [2:0] S_DONE   = ST_DONE;

   if (N < 2) begin : g_bad_n
      $error("maxnet_controller: N must be at least 2");
   end
   if (MAX_ITER < 1 || MAX_ITER > (2 ** ITER_W) - 1) begin : g_bad_max_iter
      $error("maxnet_controller: MAX_ITER must fit in ITER_W bits and be nonzero");
   end

   logic [2:0]        r_state;
   logic              r_start_q;
   logic [IDX_W-1:0]  r_mem_addr;
   logic [ITER_W-1:0] r_iter_count;
   logic [IDX_W-1:0]  r_winner;
   logic              r_timeout;

   logic              w_start_rise;
   logic              w_le_one;
   logic [IDX_W-1:0]  w_lowest_idx;
   logic              w_at_limit;

   assign w_start_rise = i_start & ~r_start_q;

   maxnet_winner_detect #(
      .N (N)
   ) u_winner_detect (
      .i_nz_flags   (i_nz_flags),
      .o_le_one     (w_le_one),
      .o_lowest_idx (w_lowest_idx)
   );

`ifdef MAXNET_ITER_LIMIT_EN
   assign w_at_limit = (r_iter_count == ITER_W'(MAX_ITER));
`else
   assign w_at_limit = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_start_q    <= 1'b0;
         r_mem_addr   <= '0;
         r_iter_count <= '0;
         r_winner     <= '0;
         r_timeout    <= 1'b0;
      end else begin
         r_start_q <= i_start;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_rise) begin
                  r_state      <= S_LOAD;
                  r_mem_addr   <= '0;
                  r_iter_count <= '0;
                  r_winner     <= '0;
                  r_timeout    <= 1'b0;
               end
            end
            S_LOAD: begin
               if (r_mem_addr == IDX_W'(N - 1)) begin
                  r_state    <= S_CALC;
                  r_mem_addr <= '0;
               end else begin
                  r_mem_addr <= r_mem_addr + 1'b1;
               end
            end
            S_CALC: r_state <= S_UPDATE;
            S_UPDATE: begin
               if (r_iter_count != '1) r_iter_count <= r_iter_count + 1'b1;
               r_state <= S_CHECK;
            end
            S_CHECK: begin
               // Convergence takes priority over the iteration limit.
               if (w_le_one) begin
                  r_state  <= S_DONE;
                  r_winner <= w_lowest_idx;
               end else if (w_at_limit) begin
                  r_state   <= S_DONE;
                  r_winner  <= w_lowest_idx;
                  r_timeout <= 1'b1;
               end else begin
                  r_state <= S_CALC;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_mem_addr   = r_mem_addr;
   assign o_ld_init    = (r_state == S_LOAD);
   assign o_calc_en    = (r_state == S_CALC);
   assign o_ld_update  = (r_state == S_UPDATE);
   assign o_iter_count = r_iter_count;
   assign o_winner     = r_winner;
   assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
   assign o_done       = (r_state == S_DONE);
   assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed-vector bench for maxnet_controller (N=4, ITER_W=8, MAX_ITER=5).
module tb_maxnet_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] nz_flags;
   logic [1:0] mem_addr;
   logic       ld_init;
   logic       calc_en;
   logic       ld_update;
   logic [7:0] iter_count;
   logic [1:0] winner;
   logic       busy;
   logic       done;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   maxnet_controller #(
      .N        (4),
      .ITER_W   (8),
      .MAX_ITER (5)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_nz_flags   (nz_flags),
      .o_mem_addr   (mem_addr),
      .o_ld_init    (ld_init),
      .o_calc_en    (calc_en),
      .o_ld_update  (ld_update),
      .o_iter_count (iter_count),
      .o_winner     (winner),
      .o_busy       (busy),
      .o_done       (done),
      .o_timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int all_outs();
      return int'({mem_addr, ld_init, calc_en, ld_update, iter_count,
                   winner, busy, done, timeout});
   endfunction

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      nz_flags = 4'b0000;
      #3;
      chk("reset_outs", all_outs(), 0);
      #10 rst = 1'b0;
      tick();

      // Reset mid-LOAD aborts immediately.
      nz_flags = 4'b0100;
      start    = 1'b1;
      tick();
      chk("abort_ld0", int'(ld_init), 1);
      tick();
      tick();
      chk("abort_addr2", int'(mem_addr), 2);
      #2 rst = 1'b1;
      start = 1'b0;
      #1;
      chk("abort_outs", all_outs(), 0);
      #1 rst = 1'b0;
      tick();

      // Single iteration, winner 2.
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("load_ld_init", int'(ld_init), 1);
         chk("load_addr", int'(mem_addr), i);
         tick();
      end
      chk("calc_en", int'(calc_en), 1);
      chk("calc_ld_init", int'(ld_init), 0);
      tick();
      chk("ld_update", int'(ld_update), 1);
      tick();
      chk("check_iter", int'(iter_count), 1);
      chk("check_done", int'(done), 0);
      tick();
      chk("r1_done", int'(done), 1);
      chk("r1_busy", int'(busy), 0);
      chk("r1_winner", int'(winner), 2);
      chk("r1_iter", int'(iter_count), 1);
      chk("r1_timeout", int'(timeout), 0);

      // Three iterations, winner 3.
      start = 1'b0;
      tick();
      start    = 1'b1;
      nz_flags = 4'b1011;
      tick();
      chk("r2_cleared", int'({iter_count, winner}), 0);
      chk("r2_busy", int'(busy), 1);
      repeat (10) tick();
      nz_flags = 4'b1000;
      tick();
      tick();
      chk("r2_not_yet", int'(done), 0);
      tick();
      chk("r2_done", int'(done), 1);
      chk("r2_iter", int'(iter_count), 3);
      chk("r2_winner", int'(winner), 3);

      // Held start gives exactly one run; re-raise starts another.
      start = 1'b0;
      tick();
      nz_flags = 4'b0100;
      start    = 1'b1;
      repeat (10) tick();
      chk("hold_done", int'(done), 1);
      chk("hold_iter", int'(iter_count), 1);
      chk("hold_winner", int'(winner), 2);
      start = 1'b0;
      tick();
      chk("hold_keep", int'(done), 1);
      start    = 1'b1;
      nz_flags = 4'b0000;
      tick();
      chk("rerun_busy", int'(busy), 1);
      chk("rerun_done", int'(done), 0);
      chk("rerun_clear", int'({iter_count, winner}), 0);
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      chk("busy_edge_addr", int'(mem_addr), 3);
      tick();
      chk("busy_edge_calc", int'(calc_en), 1);
      repeat (3) tick();
      chk("zero_done", int'(done), 1);
      chk("zero_winner", int'(winner), 0);
      chk("zero_timeout", int'(timeout), 0);
      chk("zero_iter", int'(iter_count), 1);

      // Non-converging flags: iteration limit or unbounded.
      start = 1'b0;
      tick();
      nz_flags = 4'b0110;
      start    = 1'b1;
      tick();
`ifdef MAXNET_ITER_LIMIT_EN
      repeat (18) tick();
      chk("lim_not_yet", int'(done), 0);
      tick();
      chk("lim_done", int'(done), 1);
      chk("lim_timeout", int'(timeout), 1);
      chk("lim_winner", int'(winner), 1);
      chk("lim_iter", int'(iter_count), 5);
`else
      repeat (100) tick();
      chk("unb_busy", int'(busy), 1);
      chk("unb_done", int'(done), 0);
      chk("unb_timeout", int'(timeout), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
